// File: rtl/compute_clock_pkg.sv
// Shared types for the compute-clock controller: FSM states and stop-cause encodings.
package compute_clock_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK,
    ST_SETTLE,
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  localparam logic [1:0] CAUSE_NONE   = 2'b00;
  localparam logic [1:0] CAUSE_BUDGET = 2'b01;
  localparam logic [1:0] CAUSE_STOP   = 2'b10;
  localparam logic [1:0] CAUSE_LOCK   = 2'b11;

endpackage

// File: rtl/lock_synchronizer.sv
// Brings the asynchronous MMCM lock into the control domain; latency STAGES cycles.
// Free-running flop chain, no flow control; clears to "unlocked" on reset.
module lock_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
    end
  end

  assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/compute_clock_controller.sv
// Gates the compute clock after a settled MMCM lock and counts released cycles.
// Enable changes one edge after the deciding input; lock loss overrides everything.
module compute_clock_controller
  import compute_clock_pkg::*;
#(
  parameter int CNT_W         = 32,
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 64,
  parameter int DRAIN_CYCLES  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             locked,
  input  logic             start,
  input  logic [CNT_W-1:0] budget,
  input  logic             stop,
  input  logic             clear_error,
  output logic             compute_clock_en_n,
  output logic             ready,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count,
  output logic             lock_lost,
  output logic [1:0]       stop_cause
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [DRN_W-1:0] DRAIN_LOAD  = DRN_W'(DRAIN_CYCLES - 1);

  state_t           state;
  logic             lock_s;
  logic [SET_W-1:0] settle_cnt;
  logic [DRN_W-1:0] drain_cnt;
  logic [CNT_W-1:0] budget_q;
  logic             budget_end;

  lock_synchronizer #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clock   (clock),
    .reset   (reset),
    .async_in(locked),
    .sync_out(lock_s)
  );

  assign budget_end = (budget_q != '0) && (cycle_count == budget_q - CNT_W'(1));
  assign running    = ~compute_clock_en_n;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state              <= ST_WAIT_LOCK;
      settle_cnt         <= '0;
      drain_cnt          <= '0;
      budget_q           <= '0;
      compute_clock_en_n <= 1'b1;
      ready              <= 1'b0;
      done               <= 1'b0;
      cycle_count        <= '0;
      lock_lost          <= 1'b0;
      stop_cause         <= CAUSE_NONE;
    end else begin
      done <= 1'b0;
      // A loss below is assigned later in this block, so it wins over a clear.
      if (clear_error) lock_lost <= 1'b0;

      case (state)
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state      <= ST_SETTLE;
            settle_cnt <= SETTLE_LOAD;
          end
        end

        ST_SETTLE: begin
          if (!lock_s) begin
            state <= ST_WAIT_LOCK;
          end else if (settle_cnt == '0) begin
            state <= ST_IDLE;
            ready <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - SET_W'(1);
          end
        end

        default: begin
          if (!lock_s) begin
            state              <= ST_WAIT_LOCK;
            ready              <= 1'b0;
            compute_clock_en_n <= 1'b1;
            lock_lost          <= 1'b1;
            if (state == ST_RUN || state == ST_DRAIN) begin
              stop_cause <= CAUSE_LOCK;
              done       <= 1'b1;
            end
          end else begin
            case (state)
              ST_IDLE: begin
                if (start) begin
                  state              <= ST_RUN;
                  ready              <= 1'b0;
                  compute_clock_en_n <= 1'b0;
                  budget_q           <= budget;
                  cycle_count        <= '0;
                  stop_cause         <= CAUSE_NONE;
                end
              end

              ST_RUN: begin
                if (cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
                // Budget is checked first so a coincident stop reports the budget.
                if (budget_end) begin
                  compute_clock_en_n <= 1'b1;
                  stop_cause         <= CAUSE_BUDGET;
                  state              <= ST_DRAIN;
                  drain_cnt          <= DRAIN_LOAD;
                end else if (stop) begin
                  compute_clock_en_n <= 1'b1;
                  stop_cause         <= CAUSE_STOP;
                  state              <= ST_DRAIN;
                  drain_cnt          <= DRAIN_LOAD;
                end
              end

              ST_DRAIN: begin
                if (drain_cnt == '0) begin
                  done  <= 1'b1;
                  ready <= 1'b1;
                  state <= ST_IDLE;
                end else begin
                  drain_cnt <= drain_cnt - DRN_W'(1);
                end
              end

              default: begin
                state <= ST_WAIT_LOCK;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_compute_clock_controller.sv
// Directed bench for compute_clock_controller with hand-computed expectations.
module tb_compute_clock_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        locked;
  logic        start;
  logic [31:0] budget;
  logic        stop;
  logic        clear_error;
  logic        compute_clock_en_n;
  logic        ready;
  logic        running;
  logic        done;
  logic [31:0] cycle_count;
  logic        lock_lost;
  logic [1:0]  stop_cause;

  int checks = 0;
  int errors = 0;
  bit en_seen_low;
  bit done_seen;
  int n;

  always #5 clock = ~clock;

  compute_clock_controller dut (
    .clock             (clock),
    .reset             (reset),
    .locked            (locked),
    .start             (start),
    .budget            (budget),
    .stop              (stop),
    .clear_error       (clear_error),
    .compute_clock_en_n(compute_clock_en_n),
    .ready             (ready),
    .running           (running),
    .done              (done),
    .cycle_count       (cycle_count),
    .lock_lost         (lock_lost),
    .stop_cause        (stop_cause)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    en_seen_low = 1'b0;
    while (!ready && cnt < 300) begin
      tick();
      cnt++;
      if (!compute_clock_en_n) en_seen_low = 1'b1;
    end
  endtask

  task automatic count_low(output int lows);
    lows = 0;
    while (!compute_clock_en_n && lows < 1000) begin
      lows++;
      tick();
    end
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!done && cnt < 100) begin
      tick();
      cnt++;
    end
  endtask

  task automatic do_start(input logic [31:0] b);
    budget = b;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; locked = 1'b1; start = 1'b0; budget = '0;
    stop = 1'b0; clear_error = 1'b0;
    repeat (3) tick();
    check("rst_en_n", compute_clock_en_n, 1);
    check("rst_ready", ready, 0);
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    check("rst_count", cycle_count, 0);
    check("rst_lock_lost", lock_lost, 0);
    check("rst_cause", stop_cause, 0);

    // Settling time from reset release with lock already present.
    reset = 1'b0;
    wait_ready(n);
    check("settle_latency", n, 67);
    check("settle_en_stayed_high", en_seen_low, 0);

    // Budget of 5.
    do_start(32'd5);
    check("b5_running", running, 1);
    check("b5_ready_low", ready, 0);
    count_low(n);
    check("b5_low_cycles", n, 5);
    check("b5_count", cycle_count, 5);
    check("b5_cause", stop_cause, 1);
    wait_done(n);
    check("b5_done_delay", n, 4);
    check("b5_ready_with_done", ready, 1);
    tick();
    check("b5_done_single", done, 0);

    // Unbounded run, start during RUN ignored, stop after 100 cycles.
    do_start(32'd0);
    repeat (10) tick();
    budget = 32'd2;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    check("run_start_ignored_count", cycle_count, 11);
    check("run_start_ignored_en", compute_clock_en_n, 0);
    repeat (88) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_en_n", compute_clock_en_n, 1);
    check("stop_count", cycle_count, 100);
    check("stop_cause", stop_cause, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    check("drain_start_ignored_delay", n, 3);
    check("drain_start_ignored_en", compute_clock_en_n, 1);
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("idle_stop_en", compute_clock_en_n, 1);
    check("idle_stop_ready", ready, 1);
    check("idle_stop_cause", stop_cause, 2);

    // Budget of 1.
    do_start(32'd1);
    count_low(n);
    check("b1_low_cycles", n, 1);
    check("b1_count", cycle_count, 1);
    check("b1_cause", stop_cause, 1);
    wait_done(n);
    check("b1_done_delay", n, 4);

    // Stop coincident with budget end.
    do_start(32'd3);
    repeat (2) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("coinc_en_n", compute_clock_en_n, 1);
    check("coinc_cause", stop_cause, 1);
    check("coinc_count", cycle_count, 3);
    wait_done(n);
    check("coinc_done_delay", n, 4);

    // Lock loss in the middle of a run.
    tick();
    do_start(32'd0);
    repeat (10) tick();
    locked = 1'b0;
    n = 0;
    while (!compute_clock_en_n && n < 20) begin
      tick();
      n++;
    end
    check("loss_en_delay", n, 3);
    check("loss_done", done, 1);
    check("loss_cause", stop_cause, 3);
    check("loss_flag", lock_lost, 1);
    check("loss_count_frozen", cycle_count, 12);
    check("loss_ready", ready, 0);
    tick();
    check("loss_done_single", done, 0);
    clear_error = 1'b1;
    tick();
    clear_error = 1'b0;
    check("loss_clear", lock_lost, 0);

    // Loss in IDLE while clear_error is held: set wins, no done pulse.
    locked = 1'b1;
    wait_ready(n);
    check("relock_ready", ready, 1);
    locked = 1'b0;
    clear_error = 1'b1;
    repeat (3) tick();
    check("idle_loss_flag_wins", lock_lost, 1);
    check("idle_loss_no_done", done, 0);
    check("idle_loss_ready", ready, 0);
    clear_error = 1'b0;
    locked = 1'b1;
    wait_ready(n);
    clear_error = 1'b1;
    tick();
    clear_error = 1'b0;

    // Asynchronous reset in the middle of a run.
    do_start(32'd0);
    repeat (5) tick();
    check("pre_reset_running", running, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_en_n", compute_clock_en_n, 1);
    check("async_rst_count", cycle_count, 0);
    check("async_rst_running", running, 0);
    done_seen = 1'b0;
    repeat (4) begin
      tick();
      if (done) done_seen = 1'b1;
    end
    check("async_rst_no_done", done_seen, 0);
    check("async_rst_cause", stop_cause, 0);
    check("async_rst_lock_lost", lock_lost, 0);

    // Lock glitch during SETTLE restarts the wait.
    reset = 1'b0;
    repeat (20) tick();
    locked = 1'b0;
    tick();
    locked = 1'b1;
    wait_ready(n);
    check("glitch_restart_latency", n, 67);
    check("glitch_no_lock_lost", lock_lost, 0);
    check("glitch_en_stayed_high", en_seen_low, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
